onchip_mem_block_mover: RTL and testbench

Avalon-MM master that copies a block of 32-bit words from one region of the on-chip memory slave to another, one word at a time, ascending addresses. It sits between the control logic (start/length registers) and the on-chip RAM slave port (single-port, fixed read latency, byte-enabled, 32-bit). It is the initiator side of that slave interface and handles fabric waitrequest and the slave's fixed read latency.

---
 rtl/onchip_mem_mover_pkg.sv | 20 ++
 rtl/mover_rd_latency.sv | 38 +++
 rtl/onchip_mem_block_mover.sv | 180 ++++++++++++++++++
 tb/tb_onchip_mem_block_mover.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_mover_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_mover_pkg
// Shared definitions for the on-chip memory block mover: FSM state encoding,
// word/byte geometry of the RAM slave port and the fixed byte-enable value.
// -----------------------------------------------------------------------------
package onchip_mem_mover_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam int         WORD_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam logic [3:0] BE_ALL         = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } mover_state_t;

endpackage

// File: rtl/mover_rd_latency.sv
// -----------------------------------------------------------------------------
// mover_rd_latency
// Loadable down-counter. Loaded with READ_LATENCY when a read is accepted;
// 'expire' is high in the cycle the count reaches its terminal value of 1,
// which is the cycle in which the slave's readdata is valid.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   load     in   read accepted this cycle; (re)load the counter
//   expire   out  data-capture strobe
// -----------------------------------------------------------------------------
module mover_rd_latency #(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(READ_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/onchip_mem_block_mover.sv
// -----------------------------------------------------------------------------
// onchip_mem_block_mover
// Avalon-MM master that copies len 32-bit words from src_addr to dst_addr in
// the on-chip RAM, one read then one write per word, ascending addresses.
// Word pointers wrap modulo 2^(ADDR_W-2). Overlapping regions are copied in
// strictly ascending order, so dst > src with overlap replicates data.
//
// Optional feature macro: MOVER_FILL_EN
//   defined   -> fill_value / fill_mode ports exist; fill_mode=1 (latched at
//                start) writes fill_value to every destination word, no reads.
//   undefined -> copy only.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     one-cycle request, sampled only in IDLE
//   src_addr, dst_addr        byte addresses, bits [1:0] ignored
//   len                       words to move (0 allowed)
//   fill_value, fill_mode     fill pattern / fill select (MOVER_FILL_EN only)
//   busy, done, words_done    status
//   avm_*                     Avalon-MM master port to the RAM slave
// -----------------------------------------------------------------------------
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_RD      | read command at src pointer, held until accepted
// ST_RD_WAIT | counting slave read latency, capture readdata on expiry
// ST_WR      | write command at dst pointer, held until accepted
// ST_DONE    | one-cycle done pulse
// -----------------------------------------------------------------------------
module onchip_mem_block_mover
  import onchip_mem_mover_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int LEN_W        = 17,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef MOVER_FILL_EN
  input  logic [31:0]       fill_value,
  input  logic              fill_mode,
`endif
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = ADDR_W - WORD_SHIFT;

  mover_state_t      state;
  logic [PTR_W-1:0]  src_ptr;
  logic [PTR_W-1:0]  dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  words_done_q;
  logic [31:0]       data_q;
  logic              fill_q;
  logic              fill_req;
  logic [31:0]       fill_word;
  logic              rd_accept;
  logic              wr_accept;
  logic              lat_expire;
  logic              unused_addr_lsbs;

`ifdef MOVER_FILL_EN
  assign fill_req  = fill_mode;
  assign fill_word = fill_value;
`else
  assign fill_req  = 1'b0;
  assign fill_word = '0;
`endif

  // Byte offset bits of the request addresses are don't-care.
  assign unused_addr_lsbs = ^{src_addr[WORD_SHIFT-1:0], dst_addr[WORD_SHIFT-1:0]};

  assign rd_accept = (state == ST_RD) && !avm_waitrequest;
  assign wr_accept = (state == ST_WR) && !avm_waitrequest;

  mover_rd_latency #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_latency (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (rd_accept),
    .expire (lat_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      remaining    <= '0;
      words_done_q <= '0;
      data_q       <= '0;
      fill_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_ptr      <= src_addr[ADDR_W-1:WORD_SHIFT];
            dst_ptr      <= dst_addr[ADDR_W-1:WORD_SHIFT];
            remaining    <= len;
            words_done_q <= '0;
            fill_q       <= fill_req;
            if (len == '0) begin
              state <= ST_DONE;
            end else if (fill_req) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (rd_accept) begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (lat_expire) begin
            data_q <= avm_readdata;
            state  <= ST_WR;
          end
        end
        ST_WR: begin
          if (wr_accept) begin
            src_ptr      <= src_ptr + 1'b1;
            dst_ptr      <= dst_ptr + 1'b1;
            words_done_q <= words_done_q + 1'b1;
            remaining    <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state <= ST_DONE;
            end else if (fill_q) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Command outputs decode straight from registered state and pointers, so
  // they cannot change while the fabric holds waitrequest.
  always_comb begin
    avm_address = '0;
    if (state == ST_RD) begin
      avm_address = {src_ptr, {WORD_SHIFT{1'b0}}};
    end else if (state == ST_WR) begin
      avm_address = {dst_ptr, {WORD_SHIFT{1'b0}}};
    end
  end

  assign avm_read       = (state == ST_RD);
  assign avm_write      = (state == ST_WR);
  assign avm_byteenable = BE_ALL;
  assign avm_writedata  = fill_q ? fill_word : data_q;
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);
  assign words_done     = words_done_q;

endmodule

// File: tb/tb_onchip_mem_block_mover.sv
module tb_onchip_mem_block_mover;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] src_addr = '0;
  logic [17:0] dst_addr = '0;
  logic [16:0] len = '0;
`ifdef MOVER_FILL_EN
  logic [31:0] fill_value = '0;
  logic        fill_mode = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [16:0] words_done;
  logic [17:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        stall_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_cmd = '0;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [17:0] rd_q [$];
  logic [49:0] wr_q [$];

  onchip_mem_block_mover dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
`ifdef MOVER_FILL_EN
    .fill_value     (fill_value),
    .fill_mode      (fill_mode),
`endif
    .busy           (busy),
    .done           (done),
    .words_done     (words_done),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM slave model: read latency 1, waitrequest changes just after the edge.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address[17:2]];
    if (avm_write && !avm_waitrequest) mem[avm_address[17:2]] = avm_writedata;
  end

  always @(posedge clk) begin
    #1;
    avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Bus monitor: protocol checks and scoreboard pops on accepted commands.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (avm_read || avm_write) check("rd_wr_exclusive", 64'(avm_read && avm_write), 64'd0);
      if (prev_stall) check("stall_stable", {12'd0, avm_read, avm_write, avm_address, avm_writedata}, prev_cmd);
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      prev_cmd   = {12'd0, avm_read, avm_write, avm_address, avm_writedata};
      if (avm_read && !avm_waitrequest) begin
        rd_cnt++;
        check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) check("rd_addr", 64'(avm_address), 64'(rd_q.pop_front()));
      end
      if (avm_write && !avm_waitrequest) begin
        wr_cnt++;
        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) check("wr_addr_data", 64'({avm_address, avm_writedata}), 64'(wr_q.pop_front()));
      end
    end
  end

  task automatic model_push(input logic [17:0] s, input logic [17:0] d, input int n,
                            input logic f, input logic [31:0] fv);
    logic [15:0] sp;
    logic [15:0] dp;
    logic [31:0] v;
    sp = s[17:2];
    dp = d[17:2];
    for (int i = 0; i < n; i++) begin
      if (f) begin
        v = fv;
      end else begin
        rd_q.push_back({sp, 2'b00});
        v = ref_mem[sp];
      end
      ref_mem[dp] = v;
      wr_q.push_back({dp, 2'b00, v});
      sp++;
      dp++;
    end
  endtask

  task automatic pulse_start(input logic [17:0] s, input logic [17:0] d, input int n,
                             input logic f, input logic [31:0] fv);
    @(posedge clk);
    #1;
    rd_cnt   = 0;
    wr_cnt   = 0;
    t0       = cyc;
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = 17'(n);
`ifdef MOVER_FILL_EN
    fill_mode  = f;
    fill_value = fv;
`else
    if (f) $display("note: fill requested without MOVER_FILL_EN, value %h", fv);
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input int n, input int exp_reads);
    bit got;
    int k;
    got = 1'b0;
    k   = 0;
    while (!got && k < 3000) begin
      @(negedge clk);
      if (k == 0) check({tag, "_busy_early"}, 64'(busy), 64'd1);
      if (done) got = 1'b1;
      k++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      if (exp_cyc >= 0) check({tag, "_done_cycle"}, 64'(cyc - t0), 64'(exp_cyc));
      check({tag, "_words_done"}, 64'(words_done), 64'(n));
    end
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'(exp_reads));
    check({tag, "_wr_count"}, 64'(wr_cnt), 64'(n));
    check({tag, "_sb_empty"}, 64'(rd_q.size() + wr_q.size()), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_words_done"}, 64'(words_done), 64'd0);
    check({tag, "_read"}, 64'(avm_read), 64'd0);
    check({tag, "_write"}, 64'(avm_write), 64'd0);
    check({tag, "_address"}, 64'(avm_address), 64'd0);
    check({tag, "_writedata"}, 64'(avm_writedata), 64'd0);
    check({tag, "_byteenable"}, 64'(avm_byteenable), 64'hF);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Basic copy, no stalls: 4 words x 3 cycles + 1.
    model_push(18'h00000, 18'h00100, 4, 1'b0, 32'h0);
    pulse_start(18'h00000, 18'h00100, 4, 1'b0, 32'h0);
    wait_done("copy4", 13, 4, 4);
    for (int i = 0; i < 4; i++) check("copy4_mem", 64'(mem[16'h40 + i]), 64'(init_word(i)));

    // Zero length: done in cycle 1, no commands.
    pulse_start(18'h00010, 18'h00020, 0, 1'b0, 32'h0);
    wait_done("len0", 1, 0, 0);

    // Overlapping regions, dst above src: replication.
    model_push(18'h03000, 18'h03008, 6, 1'b0, 32'h0);
    pulse_start(18'h03000, 18'h03008, 6, 1'b0, 32'h0);
    wait_done("overlap", 19, 6, 6);
    check("overlap_rep", 64'(mem[16'h0C06]), 64'(init_word(16'h0C00)));

    // Random waitrequest on both phases.
    stall_en = 1'b1;
    model_push(18'h01000, 18'h02000, 16, 1'b0, 32'h0);
    pulse_start(18'h01000, 18'h02000, 16, 1'b0, 32'h0);
    wait_done("stall16", -1, 16, 16);
    stall_en = 1'b0;
    repeat (2) @(posedge clk);

    // Pointer wrap at the top of the address space.
    model_push(18'h3FFFC, 18'h00000, 2, 1'b0, 32'h0);
    pulse_start(18'h3FFFC, 18'h00000, 2, 1'b0, 32'h0);
    wait_done("wrap", 7, 2, 2);

`ifdef MOVER_FILL_EN
    model_push(18'h00000, 18'h00020, 3, 1'b1, 32'hDEADBEEF);
    pulse_start(18'h00000, 18'h00020, 3, 1'b1, 32'hDEADBEEF);
    wait_done("fill3", 4, 3, 0);
`endif

    // Second start while busy must not disturb the transfer.
    model_push(18'h00400, 18'h00500, 4, 1'b0, 32'h0);
    pulse_start(18'h00400, 18'h00500, 4, 1'b0, 32'h0);
    start    = 1'b1;
    src_addr = 18'h00600;
    dst_addr = 18'h00700;
    len      = 17'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("restart", 13, 4, 4);
    repeat (2) @(negedge clk);
    check("restart_stays_idle", 64'(busy), 64'd0);

    // Reset mid-transfer: abort and return to reset values immediately.
    model_push(18'h00800, 18'h00900, 8, 1'b0, 32'h0);
    pulse_start(18'h00800, 18'h00900, 8, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Fresh transfer after the abort starts from IDLE.
    model_push(18'h04000, 18'h04100, 1, 1'b0, 32'h0);
    pulse_start(18'h04000, 18'h04100, 1, 1'b0, 32'h0);
    wait_done("after_reset", 4, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
